// File: rtl/mem_pkg.sv
// Shared definitions for the writable register-file RAM and its fill engine.
package mem_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 16;

    // Fill engine state encoding
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Ceiling log2, never below 1 so counters always have at least one bit
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fill_ctrl.sv
// Bulk-fill engine: walks an index over every location once, writing a latched value.
module fill_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned IDX_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_fill_start,
    input  logic [DATA_W-1:0] i_fill_valor,
    output fill_state_t       o_state,
    output logic              o_busy,
    output logic              o_fill_we,
    output logic [IDX_W-1:0]  o_fill_idx,
    output logic [DATA_W-1:0] o_fill_valor
);

    fill_state_t       r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_valor;
    logic              r_busy;
    logic              r_we;

    // FSM, index counter and latched fill value; busy and the write strobe track FILL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_valor <= '0;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_fill_start) begin
                        r_state <= FILL;
                        r_idx   <= '0;
                        r_valor <= i_fill_valor;
                        r_busy  <= 1'b1;
                        r_we    <= 1'b1;
                    end
                end
                FILL: begin
                    // Last location written this cycle: drop busy with it, no index wrap
                    if (r_idx == IDX_W'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_we    <= 1'b0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_busy       = r_busy;
    assign o_fill_we    = r_we;
    assign o_fill_idx   = r_idx;
    assign o_fill_valor = r_valor;

endmodule

// File: rtl/ram_escritura.sv
// Register-file RAM: valid/ready write port, 1-cycle registered read, bulk fill, range flagging.
module ram_escritura
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_direccion,
    input  logic [DATA_W-1:0] wr_dato,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_direccion,
    output logic [DATA_W-1:0] dato_s,
    output logic              rd_valid,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_valor,
    output logic              busy,
    output logic              error
);

    localparam int unsigned IDX_W = clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    fill_state_t       w_state;
    logic              w_fill_we;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [DATA_W-1:0] w_fill_valor;
    logic              w_wr_acc;
    logic              w_wr_oor;
    logic              w_rd_oor;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_rd_dato;
    logic              w_error;

    fill_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_fill_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_fill_start (fill_start),
        .i_fill_valor (fill_valor),
        .o_state      (w_state),
        .o_busy       (busy),
        .o_fill_we    (w_fill_we),
        .o_fill_idx   (w_fill_idx),
        .o_fill_valor (w_fill_valor)
    );

    // Write port only open while the fill engine is idle, independent of wr_valid
    assign wr_ready = (w_state == IDLE);
    assign w_wr_acc = wr_valid && wr_ready;

    // Range checks on the full address so high addresses never alias low locations
    assign w_wr_oor = (32'(wr_direccion) >= 32'(DEPTH));
    assign w_rd_oor = (32'(rd_direccion) >= 32'(DEPTH));
    assign w_wr_en  = w_wr_acc && !w_wr_oor;
    assign w_wr_idx = wr_direccion[IDX_W-1:0];
    assign w_rd_idx = rd_direccion[IDX_W-1:0];

    // One error pulse whether the write, the read or both are out of range
    assign w_error = (w_wr_acc && w_wr_oor) || (rd_en && w_rd_oor);

    // Read data select: out of range reads zero, a same-address port write is forwarded
    always_comb begin
        w_rd_dato = '0;
        if (!w_rd_oor) begin
            if (w_wr_en && (w_wr_idx == w_rd_idx)) begin
                w_rd_dato = wr_dato;
            end else begin
                w_rd_dato = r_mem[w_rd_idx];
            end
        end
    end

    // Storage array; port writes and fill writes never coincide since the port is closed in FILL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[w_wr_idx] <= wr_dato;
            end
            if (w_fill_we) begin
                r_mem[w_fill_idx] <= w_fill_valor;
            end
        end
    end

    // Registered read port and error pulse; dato_s holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dato_s   <= '0;
            rd_valid <= 1'b0;
            error    <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            error    <= w_error;
            if (rd_en) begin
                dato_s <= w_rd_dato;
            end
        end
    end

endmodule
